// File: rtl/snd_i2s_out_if.sv
// FIFO read port between the sound sample FIFO and the I2S serialiser.
// master = sample consumer (snd_i2s_out), slave = FIFO.
interface snd_i2s_out_if;
    // Pop protocol: FIFO_RDEN is a one-cycle strobe raised only while FIFO_EMPTY is low;
    // FIFO_DOUT holds the popped word during the cycle after the strobe.
    logic [31:0] FIFO_DOUT;
    logic        FIFO_EMPTY;
    logic [10:0] FIFORDCNT;
    logic        FIFO_RDEN;

    modport master (
        input  FIFO_DOUT,
        input  FIFO_EMPTY,
        input  FIFORDCNT,
        output FIFO_RDEN
    );

    modport slave (
        output FIFO_DOUT,
        output FIFO_EMPTY,
        output FIFORDCNT,
        input  FIFO_RDEN
    );
endinterface

// File: rtl/snd_i2s_out.sv
// I2S serialiser for 32-bit stereo FIFO words (L = [31:16], R = [15:0]), 64 BCLK per
// frame, with start/stop control, one-frame prefetch and a sticky underrun flag.
module snd_i2s_out #(
    parameter int BCLK_HDIV   = 16,
    parameter int START_LEVEL = 256
) (
    input  logic          ACLK,
    input  logic          ARST,
    input  logic [1:0]    COMMAND,
    snd_i2s_out_if.master fifo,
    output logic          I2S_BCLK,
    output logic          I2S_LRCK,
    output logic          I2S_SDATA,
    output logic          PLAYING,
    output logic          UNDERRUN
);
    localparam int              DW        = (BCLK_HDIV > 2) ? $clog2(BCLK_HDIV) : 1;
    localparam logic [DW-1:0]   DIV_LAST  = DW'(BCLK_HDIV - 1);
    localparam logic [10:0]     START_CNT = 11'(START_LEVEL);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_PLAY = 2'd2
    } state_t;

    state_t        state_q;
    logic [DW-1:0] divcnt_q;
    logic          bclk_q;
    logic [5:0]    bitcnt_q;
    logic [5:0]    bitcnt_d;
    logic          lrck_q;
    logic          sdata_q;
    logic          playing_q;
    logic          underrun_q;
    logic          rden_q;
    logic          rden_dly_q;
    logic          stop_req_q;
    logic          next_vld_q;
    logic [31:0]   next_smp_q;
    logic [31:0]   shift_q;

    logic          cmd_start;
    logic          cmd_stop;
    logic          div_wrap;
    logic          bclk_fall;
    logic          frame_wrap;
    logic          prefetch;
    logic [4:0]    slot;
    logic [4:0]    bit_idx;
    logic          slot_bit;

    always_comb begin
        cmd_start  = (COMMAND == 2'b01);
        cmd_stop   = (COMMAND == 2'b10);
        div_wrap   = (divcnt_q == DIV_LAST);
        bclk_fall  = div_wrap && bclk_q;
        bitcnt_d   = bitcnt_q + 6'd1;
        frame_wrap = bclk_fall && (bitcnt_d == 6'd0);
        prefetch   = bclk_fall && (bitcnt_d == 6'd63) && !fifo.FIFO_EMPTY;
        // Slot k (1..16) of a half-frame carries channel bit 16-k; the top index bit
        // selects the left half-word while LRCK is low.
        slot       = bitcnt_d[4:0];
        bit_idx    = {~bitcnt_d[5], 4'(5'd16 - slot)};
        slot_bit   = ((slot >= 5'd1) && (slot <= 5'd16)) ? shift_q[bit_idx] : 1'b0;
    end

    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            state_q    <= S_IDLE;
            divcnt_q   <= '0;
            bclk_q     <= 1'b0;
            bitcnt_q   <= 6'd63;
            lrck_q     <= 1'b0;
            sdata_q    <= 1'b0;
            playing_q  <= 1'b0;
            underrun_q <= 1'b0;
            rden_q     <= 1'b0;
            rden_dly_q <= 1'b0;
            stop_req_q <= 1'b0;
            next_vld_q <= 1'b0;
            next_smp_q <= 32'h0;
            shift_q    <= 32'h0;
        end else begin
            rden_q     <= 1'b0;
            rden_dly_q <= rden_q;
            case (state_q)
                S_IDLE: begin
                    if (cmd_start) begin
                        state_q    <= S_FILL;
                        underrun_q <= 1'b0;
                    end
                end
                S_FILL: begin
                    if (cmd_stop) begin
                        state_q <= S_IDLE;
                    end else if ((fifo.FIFORDCNT >= START_CNT) && !fifo.FIFO_EMPTY) begin
                        state_q    <= S_PLAY;
                        playing_q  <= 1'b1;
                        rden_q     <= 1'b1;
                        divcnt_q   <= '0;
                        bclk_q     <= 1'b0;
                        bitcnt_q   <= 6'd63;
                        stop_req_q <= 1'b0;
                    end
                end
                S_PLAY: begin
                    if (cmd_stop) begin
                        stop_req_q <= 1'b1;
                    end else if (cmd_start) begin
                        stop_req_q <= 1'b0;
                    end
                    if (rden_dly_q) begin
                        next_smp_q <= fifo.FIFO_DOUT;
                        next_vld_q <= 1'b1;
                    end
                    divcnt_q <= div_wrap ? '0 : divcnt_q + DW'(1);
                    if (div_wrap) begin
                        bclk_q <= ~bclk_q;
                    end
                    if (frame_wrap && stop_req_q) begin
                        // Stop lands exactly on the frame boundary; the prefetched word is dropped.
                        state_q    <= S_IDLE;
                        playing_q  <= 1'b0;
                        bclk_q     <= 1'b0;
                        lrck_q     <= 1'b0;
                        sdata_q    <= 1'b0;
                        next_vld_q <= 1'b0;
                        stop_req_q <= 1'b0;
                        bitcnt_q   <= 6'd63;
                        divcnt_q   <= '0;
                        shift_q    <= 32'h0;
                    end else if (bclk_fall) begin
                        bitcnt_q <= bitcnt_d;
                        lrck_q   <= bitcnt_d[5];
                        sdata_q  <= slot_bit;
                        if (frame_wrap) begin
                            shift_q    <= next_vld_q ? next_smp_q : 32'h0;
                            next_vld_q <= 1'b0;
                            if (!next_vld_q) begin
                                underrun_q <= 1'b1;
                            end
                        end
                        if (prefetch) begin
                            rden_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign fifo.FIFO_RDEN = rden_q;
    assign I2S_BCLK       = bclk_q;
    assign I2S_LRCK       = lrck_q;
    assign I2S_SDATA      = sdata_q;
    assign PLAYING        = playing_q;
    assign UNDERRUN       = underrun_q;
endmodule
